// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, error codes, 25 MHz timing defaults.
// No logic; latency n/a.
// No flow control; constants only.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_WAIT_CLK,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_NOCLK = 2'b01;
  localparam logic [1:0] ERR_PKT   = 2'b10;
  localparam logic [1:0] ERR_NOACK = 2'b11;

  localparam int DEF_INHIBIT_CYCLES = 2500;
  localparam int DEF_FIRST_CLK_TMO  = 375000;
  localparam int DEF_PACKET_TMO     = 50000;
  localparam int DEF_SYNC_STAGES    = 2;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronises the raw PS/2 clk/data lines and flags ps2clk falling edges.
// Latency: SYNC_STAGES cycles on the levels, fall asserted the cycle sync_clk drops.
// No backpressure; free-running sampler.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk_in,
  input  logic ps2data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic fall
);

  logic [SYNC_STAGES-1:0] clk_pipe;
  logic [SYNC_STAGES-1:0] data_pipe;
  logic                   sync_clk_prev;

  // Idle bus is high, so resetting to 1 avoids a spurious fall after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_pipe      <= '1;
      data_pipe     <= '1;
      sync_clk_prev <= 1'b1;
    end else begin
      clk_pipe      <= {clk_pipe[SYNC_STAGES-2:0], ps2clk_in};
      data_pipe     <= {data_pipe[SYNC_STAGES-2:0], ps2data_in};
      sync_clk_prev <= sync_clk;
    end
  end

  assign sync_clk  = clk_pipe[SYNC_STAGES-1];
  assign sync_data = data_pipe[SYNC_STAGES-1];
  assign fall      = sync_clk_prev & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with inhibit, request-to-send, ACK check and timeouts.
// Latency: INHIBIT_CYCLES plus device clocking; tx_done one cycle after the bus is seen idle.
// tx_start accepted only while tx_busy=0; requests while busy are dropped.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int FIRST_CLK_TMO  = DEF_FIRST_CLK_TMO,
  parameter int PACKET_TMO     = DEF_PACKET_TMO,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_drive_low,
  output logic       ps2data_drive_low
);

  localparam int TMAX_A = (FIRST_CLK_TMO > PACKET_TMO) ? FIRST_CLK_TMO : PACKET_TMO;
  localparam int TMAX   = (TMAX_A > INHIBIT_CYCLES) ? TMAX_A : INHIBIT_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] INH_RTS  = TW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] CLK_LAST = TW'(FIRST_CLK_TMO - 1);
  localparam logic [TW-1:0] PKT_LAST = TW'(PACKET_TMO - 1);

  logic sync_clk, sync_data, fall;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .ps2clk_in (ps2clk_in),
    .ps2data_in(ps2data_in),
    .sync_clk  (sync_clk),
    .sync_data (sync_data),
    .fall      (fall)
  );

  state_t          state, state_nxt;
  logic [8:0]      shreg, shreg_nxt;
  logic [3:0]      bitcnt, bitcnt_nxt;
  logic [TW-1:0]   timer, timer_nxt, timer_inc;
  logic            clk_low_nxt, data_low_nxt, done_nxt;
  logic [1:0]      err_code_nxt;
  logic            go_err;
  logic [1:0]      go_code;

  assign timer_inc = (&timer) ? timer : timer + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      shreg             <= '0;
      bitcnt            <= '0;
      timer             <= '0;
      ps2clk_drive_low  <= 1'b0;
      ps2data_drive_low <= 1'b0;
      err_code          <= ERR_NONE;
      tx_done           <= 1'b0;
    end else begin
      state             <= state_nxt;
      shreg             <= shreg_nxt;
      bitcnt            <= bitcnt_nxt;
      timer             <= timer_nxt;
      ps2clk_drive_low  <= clk_low_nxt;
      ps2data_drive_low <= data_low_nxt;
      err_code          <= err_code_nxt;
      tx_done           <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bitcnt_nxt   = bitcnt;
    timer_nxt    = timer_inc;
    clk_low_nxt  = ps2clk_drive_low;
    data_low_nxt = ps2data_drive_low;
    err_code_nxt = err_code;
    done_nxt     = 1'b0;
    go_err       = 1'b0;
    go_code      = ERR_NONE;

    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        // tx_done high means the previous transfer's pulse cycle, still busy.
        if (tx_start && !tx_done) begin
          shreg_nxt    = {odd_parity(tx_data), tx_data};
          bitcnt_nxt   = '0;
          err_code_nxt = ERR_NONE;
          clk_low_nxt  = 1'b1;
          data_low_nxt = 1'b0;
          state_nxt    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer >= INH_RTS) data_low_nxt = 1'b1;
        if (timer == INH_LAST) begin
          clk_low_nxt = 1'b0;
          timer_nxt   = '0;
          state_nxt   = ST_WAIT_CLK;
        end
      end
      ST_WAIT_CLK: begin
        if (fall) begin
          data_low_nxt = ~shreg[0];
          shreg_nxt    = {1'b0, shreg[8:1]};
          bitcnt_nxt   = 4'd1;
          timer_nxt    = '0;
          state_nxt    = ST_SEND;
        end else if (timer == CLK_LAST) begin
          go_err  = 1'b1;
          go_code = ERR_NOCLK;
        end
      end
      ST_SEND: begin
        if (timer == PKT_LAST) begin
          go_err  = 1'b1;
          go_code = ERR_PKT;
        end else if (fall) begin
          bitcnt_nxt = bitcnt + 4'd1;
          // Tenth fall: release data as the stop bit.
          if (bitcnt == 4'd9) begin
            data_low_nxt = 1'b0;
            state_nxt    = ST_ACK;
          end else begin
            data_low_nxt = ~shreg[0];
            shreg_nxt    = {1'b0, shreg[8:1]};
          end
        end
      end
      ST_ACK: begin
        if (timer == PKT_LAST) begin
          go_err  = 1'b1;
          go_code = ERR_PKT;
        end else if (fall) begin
          bitcnt_nxt = bitcnt + 4'd1;
          if (sync_data) begin
            go_err  = 1'b1;
            go_code = ERR_NOACK;
          end else begin
            state_nxt = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (timer == PKT_LAST) begin
          go_err  = 1'b1;
          go_code = ERR_PKT;
        end else if (sync_clk && sync_data) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        clk_low_nxt  = 1'b0;
        data_low_nxt = 1'b0;
        state_nxt    = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (go_err) begin
      err_code_nxt = go_code;
      clk_low_nxt  = 1'b0;
      data_low_nxt = 1'b0;
      state_nxt    = ST_ERR;
    end
  end

  assign tx_err  = (state == ST_ERR);
  assign tx_busy = (state != ST_IDLE) | tx_done;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Scaled-down timing parameters keep the run short.
module tb_ps2_host_tx;

  localparam int INH  = 60;
  localparam int FCT  = 1000;
  localparam int PKT  = 1500;
  localparam int SYNC = 2;
  localparam int HALF = 20;

  localparam int M_OK    = 0;
  localparam int M_NOCLK = 1;
  localparam int M_NOACK = 2;
  localparam int M_STOP4 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2clk_drive_low, ps2data_drive_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  wire ps2clk_line  = ~(ps2clk_drive_low | dev_clk_low);
  wire ps2data_line = ~(ps2data_drive_low | dev_data_low);

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int         bfm_mode = M_OK;
  logic       bfm_arm = 1'b0;
  logic       bfm_active = 1'b0;
  int         bfm_falls = 0;
  int         first_fall_cyc = 0;
  logic [9:0] cap = '0;

  int low_run = 0;
  int last_low_run = 0;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FIRST_CLK_TMO (FCT),
    .PACKET_TMO    (PKT),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk              (clk),
    .reset            (rst),
    .tx_data          (tx_data),
    .tx_start         (tx_start),
    .tx_busy          (tx_busy),
    .tx_done          (tx_done),
    .tx_err           (tx_err),
    .err_code         (err_code),
    .ps2clk_in        (ps2clk_line),
    .ps2data_in       (ps2data_line),
    .ps2clk_drive_low (ps2clk_drive_low),
    .ps2data_drive_low(ps2data_drive_low)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Length of the most recent host clock-inhibit run.
  always @(negedge clk) begin
    if (ps2clk_drive_low) low_run <= low_run + 1;
    else begin
      if (low_run > 0) last_low_run <= low_run;
      low_run <= 0;
    end
  end

  // Device model: waits for request-to-send, clocks 11 bits, samples on the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bfm_arm && !rst && bfm_mode != M_NOCLK && !ps2clk_drive_low && ps2data_drive_low) begin
        bfm_arm = 1'b0; bfm_active = 1'b1; bfm_falls = 0; cap = '0;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
          if (bfm_mode == M_STOP4 && k == 6) break;
          if (k == 11 && bfm_mode != M_NOACK) dev_data_low = 1'b1;
          repeat (2) @(negedge clk);
          dev_clk_low = 1'b1;
          bfm_falls = k;
          if (k == 1) first_fall_cyc = cyc;
          repeat (HALF) @(negedge clk);
          dev_clk_low = 1'b0;
          if (k <= 10) cap[k-1] = ps2data_line;
          repeat (HALF - 2) @(negedge clk);
        end
        dev_data_low = 1'b0;
        bfm_active = 1'b0;
      end
    end
  end

  // Expected on-wire frame {stop, parity, d7..d0}: parity makes the count of ones odd.
  function automatic logic [9:0] frame_model(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i] ? 1 : 0;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input int mode, output int elapsed,
                          output int pulse_cyc, output int ndone, output int nerr,
                          output logic busy_at_pulse);
    int   s;
    logic pulsed;
    bfm_mode = mode; bfm_arm = 1'b1;
    elapsed = -1; pulse_cyc = 0; ndone = 0; nerr = 0; busy_at_pulse = 1'b0; pulsed = 1'b0;
    @(negedge clk); tx_data = d; tx_start = 1'b1; s = cyc;
    @(negedge clk); tx_start = 1'b0; tx_data = 8'($urandom);
    for (int i = 0; i < 4000; i++) begin
      tx_start = 1'b0;
      if (i == 10) begin tx_start = 1'b1; tx_data = ~d; end
      if (tx_done || tx_err) begin
        ndone += tx_done ? 1 : 0;
        nerr  += tx_err ? 1 : 0;
        if (!pulsed) begin
          pulsed = 1'b1; elapsed = cyc - s; pulse_cyc = cyc; busy_at_pulse = tx_busy;
          tx_start = 1'b1; tx_data = 8'h55;
        end
      end
      if (pulsed && (cyc - s) > elapsed + 10) break;
      @(negedge clk);
    end
    tx_start = 1'b0; bfm_arm = 1'b0;
    for (int i = 0; i < 2000 && bfm_active; i++) @(negedge clk);
  endtask

  initial begin
    int         el, pc, nd, ne;
    logic       bp;
    logic [7:0] d;
    logic [7:0] pat [3];
    logic       par [3];
    pat = '{8'h00, 8'hFF, 8'h01};
    par = '{1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_clk_drive", ps2clk_drive_low, 0);
    chk("rst_data_drive", ps2data_drive_low, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer(8'hED, M_OK, el, pc, nd, ne, bp);
    chk("t1_done_pulses", nd, 1);
    chk("t1_err_pulses", ne, 0);
    chk("t1_frame_const", cap, 10'h3ED);
    chk("t1_frame_model", cap, frame_model(8'hED));
    chk("t1_inhibit_min", last_low_run >= INH, 1);
    chk("t1_inhibit_max", last_low_run <= INH + 2, 1);
    chk("t1_busy_at_pulse", bp, 1);
    chk("t1_err_code", err_code, 0);
    chk("t1_start_at_pulse_ignored", tx_busy, 0);

    for (int i = 0; i < 7; i++) begin
      d = (i < 3) ? pat[i] : 8'($urandom);
      run_xfer(d, M_OK, el, pc, nd, ne, bp);
      chk("t2_done", nd, 1);
      chk("t2_frame", cap, frame_model(d));
      if (i < 3) chk("t2_parity", cap[8], par[i]);
    end

    run_xfer(8'($urandom), M_NOCLK, el, pc, nd, ne, bp);
    chk("t3_err", ne, 1);
    chk("t3_done", nd, 0);
    chk("t3_err_code", err_code, 2'b01);
    chk("t3_latency", (el >= INH + FCT - 2) && (el <= INH + FCT + 2), 1);
    chk("t3_clk_released", ps2clk_drive_low, 0);
    chk("t3_data_released", ps2data_drive_low, 0);

    d = 8'($urandom);
    run_xfer(d, M_NOACK, el, pc, nd, ne, bp);
    chk("t4_err", ne, 1);
    chk("t4_done", nd, 0);
    chk("t4_err_code", err_code, 2'b11);
    chk("t4_frame", cap, frame_model(d));
    run_xfer(8'hF4, M_OK, el, pc, nd, ne, bp);
    chk("t4_retry_done", nd, 1);
    chk("t4_retry_err_code", err_code, 2'b00);
    chk("t4_retry_frame", cap, frame_model(8'hF4));

    run_xfer(8'($urandom), M_STOP4, el, pc, nd, ne, bp);
    chk("t5_err", ne, 1);
    chk("t5_err_code", err_code, 2'b10);
    chk("t5_window", (pc - first_fall_cyc >= PKT) && (pc - first_fall_cyc <= PKT + SYNC + 6), 1);

    bfm_mode = M_OK; bfm_falls = 0; bfm_arm = 1'b1;
    d = 8'($urandom) & 8'hF7;
    @(negedge clk); tx_data = d; tx_start = 1'b1;
    @(negedge clk); tx_start = 1'b0;
    for (int i = 0; i < 3000 && bfm_falls < 4; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t6_in_send", (bfm_falls >= 4) && tx_busy, 1);
    chk("t6_data_driven", ps2data_drive_low, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_clk_drive", ps2clk_drive_low, 0);
    chk("t6_rst_data_drive", ps2data_drive_low, 0);
    chk("t6_rst_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bfm_arm = 1'b0;
    for (int i = 0; i < 2000 && bfm_active; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    d = 8'($urandom);
    run_xfer(d, M_OK, el, pc, nd, ne, bp);
    chk("t6_after_done", nd, 1);
    chk("t6_after_frame", cap, frame_model(d));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
